// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and helpers for the UART TX arbiter and,
// later, the RX demultiplexer.
//   arb_state_t      : arbiter FSM states (IDLE, HDR, PASS)
//   HDR_BASE_DEFAULT : default upper bits of the channel header byte
//   next_rr()        : round-robin winner search over up to MAX_CH requests
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PASS = 2'd2
  } arb_state_t;

  localparam logic [7:0] HDR_BASE_DEFAULT = 8'hF0;
  localparam int         MAX_CH           = 8;

  // Returns the first requesting index found when searching last+1,
  // last+2, ... modulo num_ch, or -1 when nothing is requesting.
  function automatic int next_rr(input logic [MAX_CH-1:0] req,
                                 input logic [2:0]        last,
                                 input int                num_ch);
    int         winner;
    int         idx;
    logic [2:0] idx3;
    winner = -1;
    for (int i = 1; i <= MAX_CH; i++) begin
      idx  = (int'(last) + i) % num_ch;
      idx3 = 3'(idx);
      if (i <= num_ch && winner < 0 && req[idx3]) begin
        winner = idx;
      end
    end
    return winner;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin priority encoder.
//   req    : per-channel request vector
//   last   : index of the previously served channel (lowest priority now)
//   winner : selected channel index (valid when found=1)
//   found  : at least one request is set
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic [IDX_W-1:0]  winner,
  output logic              found
);

  logic [MAX_CH-1:0] req_ext;
  int                pick;

  always_comb begin
    req_ext             = '0;
    req_ext[NUM_CH-1:0] = req;
    pick                = next_rr(req_ext, 3'(last), NUM_CH);
    found               = (pick >= 0);
    winner              = found ? IDX_W'(pick) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter sharing one uart_tx
// byte stream among NUM_CH AXI-Stream byte sources. A grant is held from
// the first byte until tlast, or until MAX_BURST bytes (0 = unlimited).
// Optional build macro UART_ARB_HDR_EN: each grant starts with a header
// byte HDR_BASE | grant_id so the receiver can demultiplex.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   s_axis_tvalid/tready  : per-channel handshake (NUM_CH bits)
//   s_axis_tdata          : channel i on bits [8i+7:8i]
//   s_axis_tlast          : per-channel end of packet
//   m_axis_tvalid/tready  : handshake towards uart_tx
//   m_axis_tdata          : byte towards uart_tx
//   grant_id              : currently granted channel (registered)
//   busy                  : a grant is active
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int         NUM_CH    = 4,
  parameter  int         MAX_BURST = 256,
  parameter  logic [7:0] HDR_BASE  = HDR_BASE_DEFAULT,
  localparam int         IDX_W     = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   s_axis_tvalid,
  output logic [NUM_CH-1:0]   s_axis_tready,
  input  logic [NUM_CH*8-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]   s_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [7:0]          m_axis_tdata,
  output logic [IDX_W-1:0]    grant_id,
  output logic                busy
);

  localparam int CNT_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LAST =
      (MAX_BURST == 0) ? '0 : CNT_W'(MAX_BURST - 1);

  arb_state_t       state_reg, state_next;
  logic [IDX_W-1:0] last_grant_reg;
  logic [IDX_W-1:0] grant_id_reg;
  logic [CNT_W-1:0] burst_cnt_reg;

  logic [IDX_W-1:0] winner;
  logic             found;
  logic             grant_load;
  logic             xfer;
  logic             burst_hit;
  logic             release_now;

  logic [7:0] lane [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
    assign lane[gi] = s_axis_tdata[8*gi +: 8];
  end

  rr_picker #(
    .NUM_CH (NUM_CH)
  ) u_picker (
    .req    (s_axis_tvalid),
    .last   (last_grant_reg),
    .winner (winner),
    .found  (found)
  );

  always_comb begin
    state_next    = state_reg;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    s_axis_tready = '0;
    grant_load    = 1'b0;
    xfer          = 1'b0;
    release_now   = 1'b0;
    burst_hit     = (MAX_BURST != 0) && (burst_cnt_reg == BURST_LAST);
    case (state_reg)
      IDLE: begin
        if (found) begin
          grant_load = 1'b1;
`ifdef UART_ARB_HDR_EN
          state_next = HDR;
`else
          state_next = PASS;
`endif
        end
      end
      // Only reachable when the header feature is built in.
      HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = HDR_BASE | 8'(grant_id_reg);
        if (m_axis_tready) begin
          state_next = PASS;
        end
      end
      PASS: begin
        m_axis_tvalid               = s_axis_tvalid[grant_id_reg];
        m_axis_tdata                = lane[grant_id_reg];
        s_axis_tready[grant_id_reg] = m_axis_tready;
        xfer                        = m_axis_tvalid & m_axis_tready;
        // A burst-limit release is not a packet end: the channel keeps
        // its remaining bytes and re-competes from IDLE.
        if (xfer && (s_axis_tlast[grant_id_reg] || burst_hit)) begin
          release_now = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= IDX_W'(NUM_CH - 1);
      grant_id_reg   <= '0;
      burst_cnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (grant_load) begin
        grant_id_reg  <= winner;
        burst_cnt_reg <= '0;
      end else if (xfer) begin
        burst_cnt_reg <= burst_cnt_reg + 1'b1;
      end
      if (release_now) begin
        last_grant_reg <= grant_id_reg;
      end
    end
  end

  assign grant_id = grant_id_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter
// (NUM_CH=4, MAX_BURST=4). Cycle table for the basic packet path, queue
// driven streams for multi-cycle corner cases, and randomized traffic
// checked against a packet-level round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int NUM_CH    = 4;
  localparam int MAX_BURST = 4;
`ifdef UART_ARB_HDR_EN
  localparam bit HDR_ON = 1'b1;
`else
  localparam bit HDR_ON = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NUM_CH-1:0]   s_tvalid = '0;
  logic [NUM_CH-1:0]   s_tready;
  logic [NUM_CH*8-1:0] s_tdata = '0;
  logic [NUM_CH-1:0]   s_tlast = '0;
  logic                m_tvalid;
  logic                m_tready = 1'b0;
  logic [7:0]          m_tdata;
  logic [1:0]          grant_id;
  logic                busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_CH    (NUM_CH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  // Per-cycle table vector: inputs then expected outputs.
  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        mr;
    logic        e_mv;
    logic [7:0]  e_md;
    logic [3:0]  e_sr;
    logic [1:0]  e_gid;
    logic        e_busy;
  } vec_t;

  typedef struct {
    bit         hdr;
    int         ch;
    logic [7:0] data;
  } exp_t;

  vec_t       tbl[$];
  exp_t       exp_q[$];
  logic [7:0] qd[NUM_CH][$];
  bit         ql[NUM_CH][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_grant(input int ch);
    if (HDR_ON) exp_q.push_back('{1'b1, ch, 8'hF0 | 8'(ch)});
  endtask

  task automatic exp_data(input int ch, input logic [7:0] b);
    exp_q.push_back('{1'b0, ch, b});
  endtask

  task automatic load_pkt(input int ch, input logic [7:0] first, input int len);
    for (int i = 0; i < len; i++) begin
      qd[ch].push_back(first + 8'(i));
      ql[ch].push_back(i == len - 1);
    end
  endtask

  task automatic drive_sources();
    for (int c = 0; c < NUM_CH; c++) begin
      s_tvalid[c]       = (qd[c].size() > 0);
      s_tdata[c*8 +: 8] = (qd[c].size() > 0) ? qd[c][0] : 8'h00;
      s_tlast[c]        = (ql[c].size() > 0) ? ql[c][0] : 1'b0;
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic bit all_empty();
    for (int c = 0; c < NUM_CH; c++) if (qd[c].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  // Runs the source queues into the DUT, checking every output transfer
  // against exp_q in order. stop_pops > 0 stops after that many data pops.
  task automatic run_stream(input int stall_pct, input int stop_pops, input int max_cycles);
    int k = 0;
    int pops = 0;
    int cyc = 0;
    bit done = 1'b0;
    while (!done) begin
      drive_sources();
      m_tready = ($urandom_range(99) >= stall_pct);
      @(negedge clk);
      if (m_tvalid && m_tready) begin
        int popped = 0;
        int pch = -1;
        for (int c = 0; c < NUM_CH; c++) begin
          if (s_tready[c] && s_tvalid[c]) begin
            popped++;
            pch = c;
          end
        end
        $display("xfer ch=%0d data=%02h", grant_id, m_tdata);
        if (k < exp_q.size()) begin
          check("stream_byte", {22'd0, grant_id, m_tdata}, {22'd0, 2'(exp_q[k].ch), exp_q[k].data});
          check("stream_pop", popped, exp_q[k].hdr ? 0 : 1);
        end else begin
          check("stream_extra", k, exp_q.size());
        end
        k++;
        if (pch >= 0) begin
          void'(qd[pch].pop_front());
          void'(ql[pch].pop_front());
          pops++;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (stop_pops > 0 && pops >= stop_pops) done = 1'b1;
      else if (stop_pops == 0 && all_empty()) done = 1'b1;
      else if (cyc >= max_cycles) begin
        n_cmp++;
        n_err++;
        $display("FAIL stream_timeout: got %0d transfers expected %0d", k, exp_q.size());
        done = 1'b1;
      end
    end
    check("stream_len", k, exp_q.size());
    drive_sources();
    exp_q.delete();
  endtask

  // Reference model: packet-level round robin over non-empty channels,
  // each grant taking bytes until tlast or MAX_BURST bytes.
  task automatic build_expected(input int start_last);
    logic [7:0] md[NUM_CH][$];
    bit         ml[NUM_CH][$];
    int         last = start_last;
    for (int c = 0; c < NUM_CH; c++) begin
      md[c] = qd[c];
      ml[c] = ql[c];
    end
    while (1) begin
      int ch = -1;
      int n = 0;
      bit l = 1'b0;
      for (int i = 1; i <= NUM_CH; i++) begin
        int c = (last + i) % NUM_CH;
        if (ch < 0 && md[c].size() > 0) ch = c;
      end
      if (ch < 0) break;
      exp_grant(ch);
      while (!l && n < MAX_BURST && md[ch].size() > 0) begin
        exp_data(ch, md[ch].pop_front());
        l = ml[ch].pop_front();
        n++;
      end
      last = ch;
    end
  endtask

  initial begin
    do_reset();

    // ---- Table: ch1 sends 0x11,0x22,0x33 (stall on 0x22) ----
    tbl.push_back('{4'b0000, 4'b0000, 32'h0, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0});
    tbl.push_back('{4'b0010, 4'b0000, 32'h1100, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0});
    if (HDR_ON)
      tbl.push_back('{4'b0010, 4'b0000, 32'h1100, 1'b1, 1'b1, 8'hF1, 4'b0000, 2'd1, 1'b1});
    tbl.push_back('{4'b0010, 4'b0000, 32'h1100, 1'b1, 1'b1, 8'h11, 4'b0010, 2'd1, 1'b1});
    tbl.push_back('{4'b0010, 4'b0000, 32'h2200, 1'b0, 1'b1, 8'h22, 4'b0000, 2'd1, 1'b1});
    tbl.push_back('{4'b0010, 4'b0000, 32'h2200, 1'b1, 1'b1, 8'h22, 4'b0010, 2'd1, 1'b1});
    tbl.push_back('{4'b0010, 4'b0010, 32'h3300, 1'b1, 1'b1, 8'h33, 4'b0010, 2'd1, 1'b1});
    tbl.push_back('{4'b0000, 4'b0000, 32'h0, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd1, 1'b0});
    foreach (tbl[i]) begin
      s_tvalid = tbl[i].v;
      s_tlast  = tbl[i].l;
      s_tdata  = tbl[i].d;
      m_tready = tbl[i].mr;
      @(negedge clk);
      $display("vec %0d mv=%0b md=%02h sr=%b gid=%0d busy=%0b", i, m_tvalid, m_tdata, s_tready, grant_id, busy);
      check($sformatf("tbl%0d_mvalid", i), {31'd0, m_tvalid}, {31'd0, tbl[i].e_mv});
      check($sformatf("tbl%0d_sready", i), {28'd0, s_tready}, {28'd0, tbl[i].e_sr});
      check($sformatf("tbl%0d_grant", i), {30'd0, grant_id}, {30'd0, tbl[i].e_gid});
      check($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
      if (tbl[i].e_mv) check($sformatf("tbl%0d_mdata", i), {24'd0, m_tdata}, {24'd0, tbl[i].e_md});
      @(posedge clk);
      #1;
    end

    // ---- Burst limit: ch3 6 bytes vs ch0 1 byte, last_grant=1 ----
    load_pkt(3, 8'h30, 6);
    load_pkt(0, 8'h99, 1);
    exp_grant(3);
    for (int i = 0; i < 4; i++) exp_data(3, 8'h30 + 8'(i));
    exp_grant(0);
    exp_data(0, 8'h99);
    exp_grant(3);
    exp_data(3, 8'h34);
    exp_data(3, 8'h35);
    run_stream(0, 0, 200);

    // ---- ch0 and ch2 from reset, two identical rounds ----
    do_reset();
    for (int r = 0; r < 2; r++) begin
      qd[0].push_back(8'hA0); ql[0].push_back(1'b0);
      qd[0].push_back(8'hA1); ql[0].push_back(1'b1);
      qd[2].push_back(8'hC0); ql[2].push_back(1'b0);
      qd[2].push_back(8'hC1); ql[2].push_back(1'b1);
      exp_grant(0); exp_data(0, 8'hA0); exp_data(0, 8'hA1);
      exp_grant(2); exp_data(2, 8'hC0); exp_data(2, 8'hC1);
      run_stream(25, 0, 200);
    end

    // ---- uart_tx stall for 2000 cycles ----
    do_reset();
    load_pkt(0, 8'h5A, 1);
    drive_sources();
    m_tready = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (i >= 1)
        check("stall_hold", {18'd0, m_tvalid, busy, s_tready, grant_id, m_tdata},
              {18'd0, 1'b1, 1'b1, 4'b0000, 2'd0, HDR_ON ? 8'hF0 : 8'h5A});
      @(posedge clk);
      #1;
    end
    exp_grant(0);
    exp_data(0, 8'h5A);
    run_stream(0, 0, 50);

    // ---- reset after 2nd byte of a 4-byte ch2 packet ----
    do_reset();
    load_pkt(2, 8'h20, 4);
    exp_grant(2);
    exp_data(2, 8'h20);
    exp_data(2, 8'h21);
    run_stream(0, 2, 50);
    reset    = 1'b1;
    m_tready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("post_reset_out", {24'd0, m_tvalid, busy, s_tready, grant_id}, 32'd0);
    exp_grant(2);
    exp_data(2, 8'h22);
    exp_data(2, 8'h23);
    run_stream(0, 0, 50);

    // ---- randomized traffic against the reference model ----
    for (int it = 0; it < 8; it++) begin
      do_reset();
      for (int c = 0; c < NUM_CH; c++) begin
        int npk = $urandom_range(3);
        for (int p = 0; p < npk; p++) begin
          int len = $urandom_range(9, 1);
          for (int b = 0; b < len; b++) begin
            qd[c].push_back(8'($urandom));
            ql[c].push_back(b == len - 1);
          end
        end
      end
      build_expected(NUM_CH - 1);
      run_stream(30, 0, 3000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx byte-stream input among NUM_CH AXI-Stream byte sources.
- Packet-level round-robin: a grant is held from the first byte until tlast, or until MAX_BURST bytes have passed.
- Sits between protocol producers (ZMODEM framer, debug console, status reporter) and the uart_tx s_axis port.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8)
- MAX_BURST, 256, maximum bytes per grant before forced release; 0 = unlimited
- HDR_BASE, 8'hF0, upper bits of the channel header byte (OR-ed with the channel index; used only with UART_ARB_HDR_EN)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- s_axis_tvalid  in  NUM_CH  per-channel byte valid
- s_axis_tready  out  NUM_CH  per-channel ready
- s_axis_tdata  in  NUM_CH*8  channel i occupies bits [8i+7:8i]
- s_axis_tlast  in  NUM_CH  end of packet
- m_axis_tvalid  out  1  to uart_tx s_axis_tvalid
- m_axis_tready  in  1  from uart_tx s_axis_tready
- m_axis_tdata  out  8  to uart_tx s_axis_tdata
- grant_id  out  $clog2(NUM_CH)  currently granted channel (registered)
- busy  out  1  a grant is active (state != IDLE)

Behaviour:
- Reset values: state=IDLE, last_grant=NUM_CH-1 (so ch0 has first priority), burst_cnt=0, grant_id=0, busy=0, m_axis_tvalid=0, all s_axis_tready=0.
- State IDLE:
  - If no tvalid is set, stay in IDLE.
  - Otherwise pick the first channel with tvalid=1, searching last_grant+1, last_grant+2, ... with wrap modulo NUM_CH.
  - Register grant_id and clear burst_cnt.
  - Go to HDR if the feature is enabled, else to PASS.
  - In IDLE, m_axis_tvalid=0 and all s_axis_tready=0. This costs 1 bubble cycle per grant.
- State PASS: purely combinational datapath, zero latency.
  - m_axis_tvalid = s_axis_tvalid[grant_id]
  - m_axis_tdata = lane grant_id
  - s_axis_tready[grant_id] = m_axis_tready; all other readies = 0.
- Transfer = m_axis_tvalid & m_axis_tready. On a transfer, burst_cnt increments by 1; the counter is wide enough to hold MAX_BURST.
- PASS exit to IDLE, with last_grant <= grant_id, on a transfer where either:
  - tlast=1, or
  - MAX_BURST!=0 and burst_cnt==MAX_BURST-1.
- tvalid deasserting mid-packet (protocol violation) does not release the grant; the arbiter waits in PASS.
- A forced release at MAX_BURST is not a packet end: the channel re-competes and resumes its packet on its next grant.
- Single requester: it is re-granted after one IDLE cycle.
- Simultaneous requests on all channels: service order rotates 0,1,2,3,0...
- Reset asserted mid-packet: next cycle is IDLE with reset values. The partially sent packet is abandoned; no byte is duplicated or emitted after reset.
- An uart_tx stall (m_axis_tready=0) holds the current state with no loss; m_axis_tdata stays stable while tvalid=1.

Optional Feature:
Macro: UART_ARB_HDR_EN.
- Defined: an extra state HDR follows IDLE.
  - HDR drives m_axis_tvalid=1, m_axis_tdata=HDR_BASE|grant_id, and all s_axis_tready=0.
  - On m_axis_tready=1 it moves to PASS.
  - The header byte is not counted in burst_cnt.
  - It is emitted on every grant, including grants after a forced release, so the receiver can demultiplex.
- Undefined: no HDR state; IDLE goes directly to PASS; HDR_BASE is unused.

Decomposition:
- Package uart_arb_pkg holds:
  - the state enum (IDLE, HDR, PASS)
  - the function next_rr(req, last) returning the round-robin winner
  - the HDR_BASE default constant
- One sub-module, rr_picker: combinational round-robin priority encoder (req[NUM_CH], last index -> winner index, found flag). It is reusable by the planned RX demux.
- Mux, FSM and burst counter stay in uart_tx_arbiter.

Test Plan:
- Loopback through uart_tx/uart_rx (CLKS_PER_BIT=868); ch1 sends 3-byte packet 0x11,0x22,0x33 with tlast on 0x33 -> RX sees 0x11,0x22,0x33 in order; busy drops 1 cycle after the 0x33 handshake; grant_id=1 throughout.
- Ch0 and ch2 both hold 2-byte packets (0xA0,0xA1) and (0xC0,0xC1) from reset -> order 0xA0,0xA1,0xC0,0xC1; a second identical round also starts with ch0 (last_grant=2 wraps to 0).
- MAX_BURST=4; ch3 sends a 6-byte packet 0x30..0x35 while ch0 sends 1-byte packet 0x99 -> order 0x30..0x33, 0x99, 0x34, 0x35.
- m_axis_tready held 0 for 2000 cycles with ch0 valid on 0x5A -> m_axis_tdata stable at 0x5A, s_axis_tready[0]=0, no state change.
- Reset pulsed for 1 cycle after the 2nd byte of a 4-byte ch2 packet -> outputs at reset values next cycle; ch2's remaining bytes go out only after a new grant (which includes a header if the feature is on).
- UART_ARB_HDR_EN defined; ch2 sends 0x42 with tlast -> RX sees 0xF2 then 0x42.
